axis_frame_gen: RTL and testbench

//  Self-running AXI4-Stream frame source on the 256-bit switch datapath, with no slave inputs.

---
 rtl/axis_frame_gen.sv | 153 +++++++++++++++
 tb/tb_axis_frame_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// rtl/axis_frame_gen.sv - self-running AXI4-Stream Ethernet test frame source, 256-bit datapath
module axis_frame_gen #(
    parameter int          MIN_LEN    = 60,
    parameter int          MAX_LEN    = 1514,
    parameter int          LEN_STEP   = 1,
    parameter int          GAP_CYCLES = 0,
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = 48'h000A35000001,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter logic [2:0]  IN_PORT    = 3'd0,
    parameter logic [7:0]  OUT_PORT   = 8'h01
) (
    input  logic         clk,
    input  logic         axi_resetn,
    output logic [255:0] m_axis_tdata,
    output logic [31:0]  m_axis_tkeep,
    output logic [13:0]  m_axis_tuser_packet_length,
    output logic [2:0]   m_axis_tuser_in_port,
    output logic [7:0]   m_axis_tuser_out_port,
    output logic [2:0]   m_axis_tuser_in_vport,
    output logic [7:0]   m_axis_tuser_out_vport,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast
);

    typedef enum logic {ST_SEND, ST_GAP} state_t;

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t         r_state;
    logic [31:0]    r_seq;
    logic [13:0]    r_len;
    logic [8:0]     r_beat;      // index of the beat currently presented (or about to be)
    logic [GW-1:0]  r_gap_cnt;
    logic [255:0]   r_tdata;
    logic [31:0]    r_tkeep;
    logic [13:0]    r_plen;
    logic           r_tvalid;
    logic           r_tlast;

    logic           w_frame_done;
    logic [31:0]    w_seq_nxt;
    logic [14:0]    w_len_sum;
    logic [13:0]    w_len_nxt;
    logic [8:0]     w_beat_nxt;
    logic [143:0]   w_hdr;
    logic [255:0]   w_data;
    logic [31:0]    w_keep;
    logic           w_last;

    // Advance frame/beat bookkeeping when the presented beat is accepted
    always_comb begin
        w_frame_done = r_tvalid && m_axis_tready && r_tlast;
        w_len_sum    = {1'b0, r_len} + 15'(LEN_STEP);
        w_seq_nxt    = r_seq;
        w_len_nxt    = r_len;
        w_beat_nxt   = r_beat;
        if (w_frame_done) begin
            w_seq_nxt  = r_seq + 32'd1;
            w_len_nxt  = (w_len_sum > 15'(MAX_LEN)) ? 14'(MIN_LEN) : w_len_sum[13:0];
            w_beat_nxt = 9'd0;
        end else if (r_tvalid && m_axis_tready) begin
            w_beat_nxt = r_beat + 9'd1;
        end
    end

    // Build the contents of the next beat from sequence, length and beat index
    always_comb begin
        w_hdr  = {DST_MAC, SRC_MAC, ETHERTYPE, w_seq_nxt};
        w_data = '0;
        w_keep = '0;
        for (int k = 0; k < 32; k++) begin
            if ({w_beat_nxt, 5'(k)} < w_len_nxt) begin
                w_keep[k]       = 1'b1;
                w_data[8*k +: 8] = {w_beat_nxt[2:0], 5'(k)};
            end
        end
        // MIN_LEN >= 18 guarantees the whole header is inside the frame
        if (w_beat_nxt == 9'd0) begin
            for (int k = 0; k < 18; k++) begin
                w_data[8*k +: 8] = w_hdr[143-8*k -: 8];
            end
        end
        w_last = ({1'b0, w_beat_nxt, 5'd0} + 15'd32) >= {1'b0, w_len_nxt};
    end

    // Frame FSM: SEND loads a new beat whenever the output register is free; GAP idles
    always_ff @(posedge clk) begin
        if (!axi_resetn) begin
            r_state   <= ST_SEND;
            r_seq     <= '0;
            r_len     <= 14'(MIN_LEN);
            r_beat    <= '0;
            r_gap_cnt <= '0;
            r_tdata   <= '0;
            r_tkeep   <= '0;
            r_plen    <= 14'(MIN_LEN);
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            case (r_state)
                ST_SEND: begin
                    if (!r_tvalid || m_axis_tready) begin
                        r_seq  <= w_seq_nxt;
                        r_len  <= w_len_nxt;
                        r_beat <= w_beat_nxt;
                        if (w_frame_done && (GAP_CYCLES > 0)) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= '0;
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_tdata   <= '0;
                            r_tkeep   <= '0;
                        end else begin
                            r_tvalid <= 1'b1;
                            r_tdata  <= w_data;
                            r_tkeep  <= w_keep;
                            r_tlast  <= w_last;
                            r_plen   <= w_len_nxt;
                        end
                    end
                end
                ST_GAP: begin
                    // The cycle that loads beat 0 is the last idle cycle on the bus
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_data;
                        r_tkeep  <= w_keep;
                        r_tlast  <= w_last;
                        r_plen   <= w_len_nxt;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_SEND;
            endcase
        end
    end

    assign m_axis_tdata               = r_tdata;
    assign m_axis_tkeep               = r_tkeep;
    assign m_axis_tuser_packet_length = r_plen;
    assign m_axis_tuser_in_port       = IN_PORT;
    assign m_axis_tuser_out_port      = OUT_PORT;
    assign m_axis_tuser_in_vport      = 3'd0;
    assign m_axis_tuser_out_vport     = 8'd0;
    assign m_axis_tvalid              = r_tvalid;
    assign m_axis_tlast               = r_tlast;

endmodule

// File: tb/tb_axis_frame_gen.sv
// tb/tb_axis_frame_gen.sv - directed self-checking bench for axis_frame_gen
module tb_axis_frame_gen;

    localparam logic [111:0] HDR = 112'hFFFFFFFFFFFF_000A35000001_88B5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rdy_a, rstn_b, rdy_b;
    logic sel;

    logic [255:0] a_data, b_data;
    logic [31:0]  a_keep, b_keep;
    logic [13:0]  a_plen, b_plen;
    logic [2:0]   a_inp, b_inp, a_invp, b_invp;
    logic [7:0]   a_outp, b_outp, a_outvp, b_outvp;
    logic         a_valid, b_valid, a_last, b_last;

    axis_frame_gen #(.MIN_LEN(64), .MAX_LEN(66), .LEN_STEP(1), .GAP_CYCLES(0)) u_dut_a (
        .clk                        (clk),
        .axi_resetn                 (rstn_a),
        .m_axis_tdata               (a_data),
        .m_axis_tkeep               (a_keep),
        .m_axis_tuser_packet_length (a_plen),
        .m_axis_tuser_in_port       (a_inp),
        .m_axis_tuser_out_port      (a_outp),
        .m_axis_tuser_in_vport      (a_invp),
        .m_axis_tuser_out_vport     (a_outvp),
        .m_axis_tvalid              (a_valid),
        .m_axis_tready              (rdy_a),
        .m_axis_tlast               (a_last)
    );

    axis_frame_gen #(.MIN_LEN(20), .MAX_LEN(20), .LEN_STEP(1), .GAP_CYCLES(3)) u_dut_b (
        .clk                        (clk),
        .axi_resetn                 (rstn_b),
        .m_axis_tdata               (b_data),
        .m_axis_tkeep               (b_keep),
        .m_axis_tuser_packet_length (b_plen),
        .m_axis_tuser_in_port       (b_inp),
        .m_axis_tuser_out_port      (b_outp),
        .m_axis_tuser_in_vport      (b_invp),
        .m_axis_tuser_out_vport     (b_outvp),
        .m_axis_tvalid              (b_valid),
        .m_axis_tready              (rdy_b),
        .m_axis_tlast               (b_last)
    );

    logic [255:0] obs_data;
    logic [31:0]  obs_keep;
    logic [13:0]  obs_plen;
    logic         obs_valid, obs_last;
    assign obs_data  = sel ? b_data  : a_data;
    assign obs_keep  = sel ? b_keep  : a_keep;
    assign obs_plen  = sel ? b_plen  : a_plen;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_last  = sel ? b_last  : a_last;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] exp_data(input logic [31:0] seq, input int len, input int b);
        logic [255:0] d;
        int i;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            i = b * 32 + k;
            if (i < len) begin
                if (i < 14)      d[8*k +: 8] = HDR[111-8*i -: 8];
                else if (i < 18) d[8*k +: 8] = seq[31-8*(i-14) -: 8];
                else             d[8*k +: 8] = i[7:0];
            end
        end
        return d;
    endfunction

    task automatic chk_beat(input string tag, input logic [31:0] seq, input int len, input int b,
                            input logic last, input logic [31:0] keep);
        chk({tag, ".tvalid"}, 256'(obs_valid), 256'(1'b1));
        chk({tag, ".tlast"},  256'(obs_last),  256'(last));
        chk({tag, ".tkeep"},  256'(obs_keep),  256'(keep));
        chk({tag, ".plen"},   256'(obs_plen),  256'(len));
        chk({tag, ".tdata"},  obs_data,        exp_data(seq, len, b));
    endtask

    // pat[c] is tready on the c-th cycle of the frame
    task automatic run_frame(input string tag, input logic [31:0] seq, input int len, input int nb,
                             input logic [31:0] keep_last, input logic [15:0] pat);
        int  b;
        int  c;
        logic r;
        b = 0;
        c = 0;
        while (b < nb && c < 64) begin
            r = pat[c % 16];
            if (sel) rdy_b = r; else rdy_a = r;
            chk_beat($sformatf("%s.b%0d.c%0d", tag, b, c), seq, len, b, (b == nb - 1),
                     (b == nb - 1) ? keep_last : 32'hFFFFFFFF);
            if (r) b++;
            c++;
            cyc();
        end
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        chk({tag, ".beats"}, 256'(b), 256'(nb));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sel    = 1'b0;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        rdy_a  = 1'b1;
        rdy_b  = 1'b1;
        cyc();
        cyc();

        // reset state
        chk("rst_a.tvalid", 256'(a_valid), 256'(1'b0));
        chk("rst_a.tlast",  256'(a_last),  256'(1'b0));
        chk("rst_a.tdata",  a_data,        256'h0);
        chk("rst_a.tkeep",  256'(a_keep),  256'h0);
        chk("rst_a.plen",   256'(a_plen),  256'd64);
        chk("rst_b.plen",   256'(b_plen),  256'd20);
        chk("rst_b.tvalid", 256'(b_valid), 256'(1'b0));

        // first beat appears one cycle after reset release
        rstn_a = 1'b1;
        cyc();
        chk("hdr.bytes0_13", 256'(a_data[111:0]), 256'(112'hB588_0100_00350A00_FFFFFFFFFFFF));
        chk("hdr.seq0",      256'(a_data[143:112]), 256'h0);
        chk("tuser.in_port",   256'(a_inp),   256'd0);
        chk("tuser.out_port",  256'(a_outp),  256'h01);
        chk("tuser.in_vport",  256'(a_invp),  256'd0);
        chk("tuser.out_vport", 256'(a_outvp), 256'd0);

        // length sweep 64,65,66,64 back-to-back
        run_frame("f0", 32'd0, 64, 2, 32'hFFFFFFFF, 16'hFFFF);
        chk("f1.seq_byte17", 256'(a_data[143:136]), 256'h01);
        run_frame("f1", 32'd1, 65, 3, 32'h00000001, 16'hFFFF);
        run_frame("f2", 32'd2, 66, 3, 32'h00000003, 16'hFFFF);
        run_frame("f3", 32'd3, 64, 2, 32'hFFFFFFFF, 16'hFFFF);

        // backpressure 1,0,0,1,0,1: outputs held while stalled, no loss/duplication
        run_frame("f4", 32'd4, 65, 3, 32'h00000001, 16'hFFE9);

        // reset on beat 1 of frame 5
        chk_beat("f5.b0", 32'd5, 66, 0, 1'b0, 32'hFFFFFFFF);
        cyc();
        chk_beat("f5.b1", 32'd5, 66, 1, 1'b0, 32'hFFFFFFFF);
        rstn_a = 1'b0;
        cyc();
        chk("mrst.tvalid", 256'(a_valid), 256'(1'b0));
        chk("mrst.tlast",  256'(a_last),  256'(1'b0));
        chk("mrst.tdata",  a_data,        256'h0);
        chk("mrst.tkeep",  256'(a_keep),  256'h0);
        chk("mrst.plen",   256'(a_plen),  256'd64);
        rstn_a = 1'b1;
        cyc();
        run_frame("r0", 32'd0, 64, 2, 32'hFFFFFFFF, 16'hFFFF);
        run_frame("r1", 32'd1, 65, 3, 32'h00000001, 16'hFFFF);

        // single-beat 20-byte frames with a 3-cycle gap
        sel    = 1'b1;
        rstn_b = 1'b1;
        cyc();
        chk("g0.byte18_19", 256'(b_data[159:144]), 256'h1312);
        run_frame("g0", 32'd0, 20, 1, 32'h000FFFFF, 16'hFFFE);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("gap0.c%0d.tvalid", g), 256'(b_valid), 256'(1'b0));
            cyc();
        end
        run_frame("g1", 32'd1, 20, 1, 32'h000FFFFF, 16'hFFFF);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("gap1.c%0d.tvalid", g), 256'(b_valid), 256'(1'b0));
            cyc();
        end
        run_frame("g2", 32'd2, 20, 1, 32'h000FFFFF, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
